time_counter: RTL
=================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of clk50m flops on clk1hz before edge detect; legal range 1..4.
REQ-002 Port: clk50m  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: clk1hz  in  1  1 Hz square wave from the divider stage; a data input, never used as a clock.
REQ-005 Port: run  in  1  1 = count seconds, 0 = hold time.
REQ-006 Port: clr  in  1  synchronous clear to 00:00:00.
REQ-007 Port: set_en  in  1  one-cycle load strobe for set_hh/set_mm/set_ss.
REQ-008 Port: set_hh, set_mm, set_ss  in  8 each  packed BCD load values; [7:4] tens, [3:0] units.
REQ-009 Port: hh, mm, ss  out  8 each  current time, packed BCD, 24-hour format.
REQ-010 Port: sec_pulse  out  1  one-cycle pulse on every tick-driven seconds advance.
REQ-011 Port: day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 advance.
REQ-012 Port: set_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-013 clk1hz SHALL pass through SYNC_STAGES flops, then a one-flop edge detector; tick = synced high AND delayed low.
REQ-014 Tick latency: when clk1hz rises before clk50m edge k, ss SHALL update at edge k+SYNC_STAGES.
REQ-015 Exactly one tick per clk1hz rising edge; the falling edge and a steady level generate none.
REQ-016 Per-cycle priority: clr > set_en > tick; a lower-priority event in the same cycle is discarded, not deferred.
REQ-017 Tick with run=1: ss units +1; units 9 -> 0 with tens +1; ss 59 -> 00 carries to mm the same way; mm 59 -> 00 carries to hh.
REQ-018 hh SHALL count 00..23; 23 -> 00 on carry. All three fields SHALL update in the same cycle, so the full cascade takes one cycle.
REQ-019 Tick with run=0: time unchanged, no sec_pulse, tick dropped (not queued).
REQ-020 sec_pulse SHALL be high in exactly the cycle after the edge where ss advances on a tick; it SHALL NOT pulse on set_en or clr.
REQ-021 day_wrap SHALL be high in the same cycle as the sec_pulse that leaves 23:59:59, and only then.
REQ-022 A load is valid only when every BCD digit <= 9, ss <= 0x59, mm <= 0x59 and hh <= 0x23.
REQ-023 Valid set_en: hh/mm/ss SHALL equal set_* on the next cycle; set_err stays 0.
REQ-024 Invalid set_en: time unchanged, set_err = 1 for one cycle; any tick in that cycle is still discarded.
REQ-025 clr: hh/mm/ss = 00 on the next cycle; no set_err, sec_pulse or day_wrap; run state is irrelevant.
REQ-026 All outputs SHALL be registered; there is no combinational path from an input to an output.
REQ-027 hh/mm/ss SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-028 rst_n low SHALL asynchronously force hh=mm=ss=0x00 and sec_pulse=day_wrap=set_err=0.
REQ-029 rst_n low SHALL force all sync flops and the edge-detect flop to 1, so releasing reset with clk1hz high produces no tick.
REQ-030 Reset release SHALL be synchronous to clk50m; the first tick needs an observed clk1hz low -> high transition.
REQ-031 Reset during a cascade (for example at 23:59:59) SHALL leave 00:00:00 with no day_wrap pulse.

Verification
REQ-032 Reset with clk1hz held high, release, run=1, then 3 clk1hz rising edges -> ss 0x00 -> 0x03, 3 sec_pulses, first ss change at edge SYNC_STAGES after the clk1hz rise.
REQ-033 set 23:59:58 with run=1, then 2 ticks -> 23:59:59, then 00:00:00; day_wrap high in the second sec_pulse cycle only.
REQ-034 set_hh=0x24 set_mm=0x00 set_ss=0x00, then set_ss=0x5A -> both rejected: time unchanged, set_err one cycle each; then 0x12/0x34/0x56 -> accepted, no set_err.
REQ-035 clr, set_en (valid 0x10:0x10:0x10) and tick in the same cycle -> 00:00:00, no sec_pulse, no set_err; then set_en plus tick in the same cycle -> loaded value exactly, no sec_pulse.
REQ-036 run=0 across 5 ticks, then run=1 -> no change and no sec_pulse while held; counting resumes +1 per later tick, no burst.
REQ-037 At 09:59:59 assert rst_n low mid-second -> outputs are zero immediately (asynchronous); after release no spurious tick while clk1hz stays high.

Source files
------------

// File: rtl/time_counter.sv
// Time-of-day counter (HH:MM:SS, packed BCD, 24-hour) advanced by a synchronised 1 Hz tick.
// Supports clear and validated load; all outputs are registered.
module time_counter #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk50m,
   input  logic       rst_n,
   input  logic       clk1hz,
   input  logic       run,
   input  logic       clr,
   input  logic       set_en,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       sec_pulse,
   output logic       day_wrap,
   output logic       set_err
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q;
   logic                   synced;
   logic                   tick;

   logic [7:0] hh_q, hh_d;
   logic [7:0] mm_q, mm_d;
   logic [7:0] ss_q, ss_d;
   logic       sec_q, sec_d;
   logic       wrap_q, wrap_d;
   logic       err_q, err_d;

   logic       load_ok;
   logic       ss_carry;
   logic       mm_carry;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] top);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= top);
   endfunction

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = clk1hz;
   end

   assign synced = sync_q[SYNC_STAGES-1];
   // Sync and edge flops reset high so a clk1hz already high at release is not a rising edge.
   assign tick   = synced & ~dly_q;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         dly_q  <= 1'b1;
      end else begin
         sync_q <= sync_d;
         dly_q  <= synced;
      end
   end

   assign load_ok  = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
   assign ss_carry = (ss_q == 8'h59);
   assign mm_carry = (mm_q == 8'h59);

   // Priority clr > set_en > tick; a losing tick is dropped, never deferred.
   always_comb begin
      hh_d   = hh_q;
      mm_d   = mm_q;
      ss_d   = ss_q;
      sec_d  = 1'b0;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (clr) begin
         hh_d = '0;
         mm_d = '0;
         ss_d = '0;
      end else if (set_en) begin
         if (load_ok) begin
            hh_d = set_hh;
            mm_d = set_mm;
            ss_d = set_ss;
         end else begin
            err_d = 1'b1;
         end
      end else if (tick && run) begin
         ss_d  = bcd_inc(ss_q, 8'h59);
         sec_d = 1'b1;
         if (ss_carry) begin
            mm_d = bcd_inc(mm_q, 8'h59);
            if (mm_carry) begin
               hh_d   = bcd_inc(hh_q, 8'h23);
               wrap_d = (hh_q == 8'h23);
            end
         end
      end
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         hh_q   <= '0;
         mm_q   <= '0;
         ss_q   <= '0;
         sec_q  <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         hh_q   <= hh_d;
         mm_q   <= mm_d;
         ss_q   <= ss_d;
         sec_q  <= sec_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign hh        = hh_q;
   assign mm        = mm_q;
   assign ss        = ss_q;
   assign sec_pulse = sec_q;
   assign day_wrap  = wrap_q;
   assign set_err   = err_q;

endmodule
